fetch_decode_queue: RTL

- Elastic packet buffer between the fetch pipeline's 128-bit packet output and the decode stage.
- Absorbs decode stalls so fetch keeps streaming, and tags each packet with its EIP.
- Flushes all contents on a writeback resteer so decode never sees wrong-path packets.
- Occupies the F2→D boundary; drives decode's packet/EIP inputs and fetch's stall input.

---
 rtl/fetch_decode_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_decode_queue.sv
// Elastic packet/EIP buffer between fetch stage 2 and decode. It absorbs decode
// stalls, keeps each packet paired with its EIP, and empties itself on a resteer.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 128,
    parameter int EIP_W = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PKT_W-1:0] packet_in,
    input  logic             packet_in_valid,
    input  logic [EIP_W-1:0] packet_in_EIP,
    input  logic             resteer,
    input  logic             D_stall,
    output logic [PKT_W-1:0] packet_out,
    output logic [EIP_W-1:0] packet_out_EIP,
    output logic             packet_out_valid,
    output logic             F_stall,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PKT_W-1:0] pkt_mem_q [DEPTH];
    logic [EIP_W-1:0] eip_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic not_empty;
    logic full;
    logic push;
    logic pop;

    // Full/empty come from the registered count only, so a full queue refuses
    // a push even in a cycle where decode is draining it.
    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign push      = packet_in_valid && !full;
    assign pop       = not_empty && !D_stall;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (resteer) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; a stale entry is never visible because the
    // head is masked whenever the queue is empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic entry_we;
            assign entry_we = push && !resteer && !reset && (wr_ptr_q == PTR_W'(gi));
            always_ff @(posedge clk) begin
                if (entry_we) begin
                    pkt_mem_q[gi] <= packet_in;
                    eip_mem_q[gi] <= packet_in_EIP;
                end
            end
        end
    endgenerate

    always_comb begin
        packet_out     = '0;
        packet_out_EIP = '0;
        if (not_empty) begin
            packet_out     = pkt_mem_q[rd_ptr_q];
            packet_out_EIP = eip_mem_q[rd_ptr_q];
        end
    end

    assign packet_out_valid = not_empty;
    assign F_stall          = full;
    assign count            = count_q;

endmodule
